// File: rtl/clk_fail_switch_ctrl_if.sv
// Select/status bundle between the clock-select controller (slave) and the system side that
// requests a source and watches health (master).
interface clk_fail_switch_ctrl_if;
    logic sw_sel;
    logic auto_en;
    logic sel;
    logic ok0;
    logic ok1;
    logic busy;
    logic fail;
    logic switch_evt;

    modport master (
        output sw_sel,
        output auto_en,
        input  sel,
        input  ok0,
        input  ok1,
        input  busy,
        input  fail,
        input  switch_evt
    );

    modport slave (
        input  sw_sel,
        input  auto_en,
        output sel,
        output ok0,
        output ok1,
        output busy,
        output fail,
        output switch_evt
    );
endinterface

// File: rtl/clk_fail_switch_ctrl.sv
// Select controller for a glitch-free two-clock mux: edge-counts both candidate clocks per window,
// applies manual/auto failover and freezes sel through the handoff. Optional macro: AUTO_REVERT_EN.
module clk_fail_switch_ctrl #(
    parameter int unsigned WIN_CYCLES     = 64,
    parameter int unsigned MIN_EDGES      = 4,
    parameter int unsigned HOLDOFF        = 16,
    parameter bit          SEL_RST        = 1'b0,
    parameter int unsigned REVERT_WINDOWS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mon_clk0,
    input  logic                  mon_clk1,
    clk_fail_switch_ctrl_if.slave bus
);
    localparam int unsigned WinW  = $clog2(WIN_CYCLES);
    localparam int unsigned CntW  = $clog2(MIN_EDGES + 1);
    localparam int unsigned HoldW = $clog2(HOLDOFF + 1);

    if (WIN_CYCLES < 4 || MIN_EDGES < 1 || MIN_EDGES > WIN_CYCLES / 2 || HOLDOFF < 1 ||
        REVERT_WINDOWS < 1) begin : g_param_err
        $error("clk_fail_switch_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {StRun, StHold, StFail} state_e;

    logic [1:0]      sync1_q, sync2_q, sync3_q;
    logic [1:0]      rise;
    logic [CntW-1:0] cnt_q [2];
    logic [WinW-1:0] win_q;
    logic            win_last;
    logic [1:0]      ok_q, ok_new;
    logic            sw_sel_q;
    state_e          state_q;
    logic            sel_q;
    logic [HoldW-1:0] hold_q;
    logic            busy_q, fail_q, switch_evt_q;
    logic            do_switch, tgt, enter_fail, leave_fail;
    logic            revert_req;

    assign rise     = sync2_q & ~sync3_q;
    assign win_last = (win_q == WinW'(WIN_CYCLES - 1));

    // An edge seen on the closing cycle still belongs to the closing window.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            ok_new[c] = (32'(cnt_q[c]) + 32'(rise[c])) >= MIN_EDGES;
        end
    end

`ifdef AUTO_REVERT_EN
    localparam int unsigned RevW = $clog2(REVERT_WINDOWS + 1);
    logic [RevW-1:0] streak_q;

    assign revert_req = (sel_q != bus.sw_sel) && ok_q[bus.sw_sel] &&
                        (streak_q >= RevW'(REVERT_WINDOWS));

    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= '0;
        end else if (do_switch) begin
            streak_q <= '0;
        end else if (win_last) begin
            if (!ok_new[bus.sw_sel]) begin
                streak_q <= '0;
            end else if (streak_q != RevW'(REVERT_WINDOWS)) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end
`else
    assign revert_req = 1'b0;
`endif

    // Decisions use the registered ok, i.e. one cycle after the window closes.
    always_comb begin
        do_switch  = 1'b0;
        tgt        = sel_q;
        enter_fail = 1'b0;
        leave_fail = 1'b0;
        unique case (state_q)
            StRun: begin
                if (!bus.auto_en) begin
                    do_switch = (bus.sw_sel != sel_q);
                    tgt       = bus.sw_sel;
                end else if (ok_q == 2'b00) begin
                    enter_fail = 1'b1;
                end else if (!ok_q[sel_q] && ok_q[~sel_q]) begin
                    do_switch = 1'b1;
                    tgt       = ~sel_q;
                end else if (revert_req) begin
                    do_switch = 1'b1;
                    tgt       = bus.sw_sel;
                end else if ((bus.sw_sel != sw_sel_q) && (bus.sw_sel != sel_q) &&
                             ok_q[bus.sw_sel]) begin
                    do_switch = 1'b1;
                    tgt       = bus.sw_sel;
                end
            end
            StFail: begin
                if (!bus.auto_en || ok_q[sel_q]) begin
                    leave_fail = 1'b1;
                end else if (ok_q[~sel_q]) begin
                    do_switch = 1'b1;
                    tgt       = ~sel_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            sw_sel_q     <= 1'b0;
            win_q        <= '0;
            cnt_q[0]     <= '0;
            cnt_q[1]     <= '0;
            ok_q         <= 2'b11;
            state_q      <= StRun;
            sel_q        <= SEL_RST;
            hold_q       <= '0;
            busy_q       <= 1'b0;
            fail_q       <= 1'b0;
            switch_evt_q <= 1'b0;
        end else begin
            sync1_q  <= {mon_clk1, mon_clk0};
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            sw_sel_q <= bus.sw_sel;

            if (win_last) begin
                win_q    <= '0;
                ok_q     <= ok_new;
                cnt_q[0] <= '0;
                cnt_q[1] <= '0;
            end else begin
                win_q <= win_q + 1'b1;
                for (int c = 0; c < 2; c++) begin
                    if (rise[c] && (cnt_q[c] != CntW'(MIN_EDGES))) begin
                        cnt_q[c] <= cnt_q[c] + 1'b1;
                    end
                end
            end

            switch_evt_q <= 1'b0;
            if (do_switch) begin
                sel_q        <= tgt;
                switch_evt_q <= 1'b1;
                hold_q       <= HoldW'(HOLDOFF - 1);
                state_q      <= StHold;
                busy_q       <= 1'b1;
                fail_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    StRun: begin
                        if (enter_fail) begin
                            state_q <= StFail;
                            fail_q  <= 1'b1;
                        end
                    end
                    StHold: begin
                        if (hold_q == '0) begin
                            state_q <= StRun;
                            busy_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                    StFail: begin
                        if (leave_fail) begin
                            state_q <= StRun;
                            fail_q  <= 1'b0;
                        end
                    end
                    default: state_q <= StRun;
                endcase
            end
        end
    end

    assign bus.sel        = sel_q;
    assign bus.ok0        = ok_q[0];
    assign bus.ok1        = ok_q[1];
    assign bus.busy       = busy_q;
    assign bus.fail       = fail_q;
    assign bus.switch_evt = switch_evt_q;
endmodule

// File: tb/tb_clk_fail_switch_ctrl.sv
// Scoreboard bench for clk_fail_switch_ctrl: directed scenarios plus random phases, checked
// against an edge-timestamp reference model of the selection rules.
module tb_clk_fail_switch_ctrl;
    localparam int WIN  = 64;
    localparam int MINE = 4;
    localparam int HOLD = 16;
    localparam int REV  = 4;
    localparam bit SEL0 = 1'b0;
    localparam int SYNC_LAT = 2;  // sampled level -> counted rise, in ref edges after sampling

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_clk0 = 1'b0;
    logic mon_clk1 = 1'b0;

    clk_fail_switch_ctrl_if bus();

    clk_fail_switch_ctrl #(
        .WIN_CYCLES    (WIN),
        .MIN_EDGES     (MINE),
        .HOLDOFF       (HOLD),
        .SEL_RST       (SEL0),
        .REVERT_WINDOWS(REV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mon_clk0(mon_clk0),
        .mon_clk1(mon_clk1),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit sel, ok0, ok1, busy, fail, evt;
    } stat_t;
    typedef struct {
        int cyc;
        bit sel;
    } evt_t;

    stat_t stat_q[$];
    evt_t  evt_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Reference model state
    int     cyc_m = 0;
    int     k_m = 0;          // ref edges since reset release
    bit     sel_m, in_fail_m, sw_prev_m;
    bit [1:0] ok_m;
    int     hold_end_m;       // busy while k_m < hold_end_m; rules resume after it
    int     cnt_w[2];
    bit     hist[2][$];       // sampled levels, newest at back
`ifdef AUTO_REVERT_EN
    int     streak_m;
`endif

    function automatic void chk(string name, int cyc, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_step();
        bit [1:0] ok_new, mon;
        bit sw, au, evt, tgt, rise;
        evt_t e;
        stat_t s;
        cyc_m++;
        evt = 1'b0;
        if (rst) begin
            k_m = 0; sel_m = SEL0; ok_m = 2'b11; in_fail_m = 0; sw_prev_m = 0;
            hold_end_m = 0;
`ifdef AUTO_REVERT_EN
            streak_m = 0;
`endif
            for (int c = 0; c < 2; c++) begin
                cnt_w[c] = 0;
                hist[c] = '{0, 0, 0, 0};
            end
        end else begin
            k_m++;
            mon = {mon_clk1, mon_clk0};
            sw  = bus.sw_sel;
            au  = bus.auto_en;
            ok_new = ok_m;
            tgt = sel_m;
            for (int c = 0; c < 2; c++) begin
                hist[c].push_back(mon[c]);
                void'(hist[c].pop_front());
                // Level sampled at edge j yields a counted rise at edge j+SYNC_LAT.
                rise = hist[c][3 - SYNC_LAT] & ~hist[c][2 - SYNC_LAT];
                cnt_w[c] += int'(rise);
                if (k_m % WIN == 0) begin
                    ok_new[c] = (cnt_w[c] >= MINE);
                    cnt_w[c] = 0;
                end
            end
            if (k_m > hold_end_m) begin
                if (in_fail_m) begin
                    if (!au || ok_m[sel_m]) in_fail_m = 0;
                    else if (ok_m[!sel_m]) begin evt = 1; tgt = !sel_m; in_fail_m = 0; end
                end else if (!au) begin
                    if (sw != sel_m) begin evt = 1; tgt = sw; end
                end else if (ok_m == 2'b00) begin
                    in_fail_m = 1;
                end else if (!ok_m[sel_m] && ok_m[!sel_m]) begin
                    evt = 1; tgt = !sel_m;
                end
`ifdef AUTO_REVERT_EN
                else if (sel_m != sw && ok_m[sw] && streak_m >= REV) begin
                    evt = 1; tgt = sw;
                end
`endif
                else if (sw != sw_prev_m && sw != sel_m && ok_m[sw]) begin
                    evt = 1; tgt = sw;
                end
            end
            if (evt) begin
                sel_m = tgt;
                hold_end_m = k_m + HOLD;
                e.cyc = cyc_m;
                e.sel = sel_m;
                evt_q.push_back(e);
            end
`ifdef AUTO_REVERT_EN
            if (evt) streak_m = 0;
            else if (k_m % WIN == 0) streak_m = ok_new[sw] ? ((streak_m < REV) ? streak_m + 1 : REV) : 0;
`endif
            ok_m = ok_new;
            sw_prev_m = sw;
        end
        s.cyc = cyc_m; s.sel = sel_m; s.ok0 = ok_m[0]; s.ok1 = ok_m[1];
        s.busy = (k_m < hold_end_m); s.fail = in_fail_m; s.evt = evt;
        stat_q.push_back(s);
    endfunction

    always @(posedge clk) model_step();

    // Monitor: one status entry per ref cycle, switch events popped when the DUT pulses.
    initial begin : monitor
        stat_t s;
        evt_t  e;
        forever begin
            @(negedge clk);
            if (stat_q.size() != 0) begin
                s = stat_q.pop_front();
                chk("sel", s.cyc, int'(bus.sel), int'(s.sel));
                chk("ok0", s.cyc, int'(bus.ok0), int'(s.ok0));
                chk("ok1", s.cyc, int'(bus.ok1), int'(s.ok1));
                chk("busy", s.cyc, int'(bus.busy), int'(s.busy));
                chk("fail", s.cyc, int'(bus.fail), int'(s.fail));
                chk("switch_evt", s.cyc, int'(bus.switch_evt), int'(s.evt));
                while (evt_q.size() != 0 && evt_q[0].cyc < s.cyc) begin
                    e = evt_q.pop_front();
                    n_cmp++;
                    n_bad++;
                    $display("FAIL missed_switch at cycle %0d: got no pulse, expected sel=%0d",
                             e.cyc, e.sel);
                end
                if (bus.switch_evt) begin
                    if (evt_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_switch at cycle %0d: got pulse, expected none",
                                 s.cyc);
                    end else begin
                        e = evt_q.pop_front();
                        chk("switch_cycle", s.cyc, s.cyc, e.cyc);
                        chk("switch_sel", s.cyc, int'(bus.sel), int'(e.sel));
                    end
                end
            end
        end
    end

    // Stimulus: 0 stopped, 1 clk/4, 2 clk/8, 3 three pulses/window, 4 four pulses/window, 5 clk/32
    int mode[2];
    int ph[2];
    int cyc_d = 0;

    function automatic logic lvl_for(int m, int p, logic cur);
        int t;
        t = (k_m + SYNC_LAT + 1) % WIN;  // window slot in which a pulse driven now is counted
        case (m)
            0: return cur;
            1: return ((cyc_d + p) % 4) < 2;
            2: return ((cyc_d + p) % 8) < 4;
            3: return (t == 10 || t == 30 || t == 0);
            4: return (t == 10 || t == 30 || t == 50 || t == 0);
            default: return ((cyc_d + p) % 32) < 16;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
        cyc_d++;
        mon_clk0 = lvl_for(mode[0], ph[0], mon_clk0);
        mon_clk1 = lvl_for(mode[1], ph[1], mon_clk1);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin : driver
        int len;
        bus.sw_sel = 1'b0;
        bus.auto_en = 1'b1;
        mode[0] = 1; mode[1] = 1; ph[0] = 0; ph[1] = 1;
        run(3);
        rst = 1'b0;
        run(640);                                  // healthy, no switching
        mode[0] = 0; run(300);                     // lose clk0 -> failover to 1
        bus.auto_en = 1'b0; mode[0] = 1; run(40);  // manual: back to sw_sel=0
        bus.sw_sel = 1'b1; run(5);
        bus.sw_sel = 1'b0; run(40);                // second request lands inside HOLD
        bus.auto_en = 1'b1;
        mode[0] = 0; mode[1] = 0; run(250);        // both lost -> FAIL
        mode[1] = 1; run(250);                     // clk1 back -> switch out of FAIL
        mode[0] = 3; mode[1] = 4; run(260);        // 3 vs 4 edges, last on closing cycle
        mode[0] = 4; mode[1] = 3; run(260);
        mode[0] = 1; mode[1] = 1; run(200);
        mode[0] = 0; run(300);                     // failover, then clk0 restored
        mode[0] = 1; run(400);
        for (int p = 0; p < 14; p++) begin
            mode[0] = $urandom_range(0, 5);
            mode[1] = $urandom_range(0, 5);
            ph[0] = $urandom_range(0, 31);
            ph[1] = $urandom_range(0, 31);
            bus.auto_en = ($urandom_range(0, 3) != 0);
            if (p == 6) begin
                rst = 1'b1;
                run(2);
                rst = 1'b0;
            end
            len = $urandom_range(150, 500);
            repeat (len) begin
                if ($urandom_range(0, 39) == 0) bus.sw_sel = ~bus.sw_sel;
                tick();
            end
        end
        run(2);
        @(negedge clk);
        #1;
        while (evt_q.size() != 0) begin
            evt_t e;
            e = evt_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missed_switch at cycle %0d: got no pulse, expected sel=%0d", e.cyc, e.sel);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
